multicycle_cpu_core: RTL and testbench

Parametrised successor to the fixed 8-bit single-cycle microprocessor top. It is a multicycle core with a fetch/decode/execute/memory/writeback FSM, a register file and an internal data memory, all generalised in data width, register count and memory depth. It advances only on a step_en qualifier, so the clock divider produces an enable tick instead of a derived clock. It drives the instruction-ROM address and exposes the last written-back value for the 7-segment display logic.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/register_file.sv | 34 +++
 rtl/multicycle_cpu_core.sv | 172 +++++++++++++++++
 tb/tb_multicycle_cpu_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM encodings and sizing helper for multicycle_cpu_core
package cpu_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BEQ   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  // Index width for a power-of-two count; never narrower than one bit.
  function automatic int reg_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - two-read one-write register file, reset to reg[i]=i
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                             i_clock,
  input  logic                             i_clear,
  input  logic [reg_bits(NUM_REGS)-1:0]    i_rs_addr,
  input  logic [reg_bits(NUM_REGS)-1:0]    i_rt_addr,
  input  logic                             i_we,
  input  logic [reg_bits(NUM_REGS)-1:0]    i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  output logic [DATA_WIDTH-1:0]            o_rs_data,
  output logic [DATA_WIDTH-1:0]            o_rt_data
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_WIDTH'(i);
      end
    end else if (i_we) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rs_data = r_regs[i_rs_addr];
  assign o_rt_data = r_regs[i_rt_addr];

endmodule

// File: rtl/multicycle_cpu_core.sv
// rtl/multicycle_cpu_core.sv - step-enabled multicycle core: fetch/decode/execute/memory/writeback
module multicycle_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int DMEM_DEPTH = 4,
  parameter int PC_WIDTH   = 8
) (
  input  logic                                clock,
  input  logic                                clear,
  input  logic                                step_en,
  input  logic [2+3*reg_bits(NUM_REGS)-1:0]   instruction,
  output logic [PC_WIDTH-1:0]                 read_address,
  output logic [DATA_WIDTH-1:0]               display_value,
  output logic [2:0]                          state,
  output logic                                retire
);

  localparam int REG_BITS    = reg_bits(NUM_REGS);
  localparam int INSTR_WIDTH = 2 + 3 * REG_BITS;
  localparam int DMEM_BITS   = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  state_t                r_state;
  state_t                w_next_state;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic [DATA_WIDTH-1:0] r_display;
  logic                  r_retire;
  logic [DATA_WIDTH-1:0] r_dmem [DMEM_DEPTH];

  logic                  w_retire;
  logic                  w_rf_we;
  logic [1:0]            w_op;
  logic [REG_BITS-1:0]   w_rs;
  logic [REG_BITS-1:0]   w_rt;
  logic [REG_BITS-1:0]   w_rd;
  logic [DATA_WIDTH-1:0] w_imm_d;
  logic [PC_WIDTH-1:0]   w_imm_p;
  logic [DMEM_BITS-1:0]  w_ea;
  logic [DMEM_BITS-1:0]  w_mem_addr;
  logic [REG_BITS-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_rs_data;
  logic [DATA_WIDTH-1:0] w_rt_data;

  assign w_op       = r_ir[INSTR_WIDTH-1 -: 2];
  assign w_rs       = r_ir[3*REG_BITS-1 -: REG_BITS];
  assign w_rt       = r_ir[2*REG_BITS-1 -: REG_BITS];
  assign w_rd       = r_ir[REG_BITS-1:0];
  assign w_imm_d    = {{(DATA_WIDTH-REG_BITS){w_rd[REG_BITS-1]}}, w_rd};
  assign w_imm_p    = {{(PC_WIDTH-REG_BITS){w_rd[REG_BITS-1]}}, w_rd};
  assign w_ea       = DMEM_BITS'(r_a + w_imm_d);
  assign w_mem_addr = r_alu[DMEM_BITS-1:0];
  assign w_wr_addr  = (w_op == OP_LOAD) ? w_rt : w_rd;
  assign w_wr_data  = (w_op == OP_LOAD) ? r_mdr : r_alu;

  register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_register_file (
    .i_clock   (clock),
    .i_clear   (clear),
    .i_rs_addr (w_rs),
    .i_rt_addr (w_rt),
    .i_we      (w_rf_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .o_rs_data (w_rs_data),
    .o_rt_data (w_rt_data)
  );

  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    w_rf_we      = 1'b0;
    if (step_en) begin
      case (r_state)
        S_FETCH:   w_next_state = S_DECODE;
        S_DECODE:  w_next_state = S_EXECUTE;
        S_EXECUTE: begin
          case (w_op)
            OP_ADD:  w_next_state = S_WRITEBACK;
            OP_BEQ: begin
              w_next_state = S_FETCH;
              w_retire     = 1'b1;
            end
            default: w_next_state = S_MEMORY;
          endcase
        end
        S_MEMORY: begin
          if (w_op == OP_LOAD) begin
            w_next_state = S_WRITEBACK;
          end else begin
            w_next_state = S_FETCH;
            w_retire     = 1'b1;
          end
        end
        S_WRITEBACK: begin
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
          w_rf_we      = 1'b1;
        end
        default:   w_next_state = S_FETCH;
      endcase
    end
  end

  // retire is a pulse, so it clears on every clock that does not retire, enabled or not.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_display <= '0;
      r_retire  <= 1'b0;
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        r_dmem[i] <= '0;
      end
    end else begin
      r_state  <= w_next_state;
      r_retire <= w_retire;
      if (step_en) begin
        case (r_state)
          S_FETCH: begin
            r_ir <= instruction;
            r_pc <= r_pc + PC_WIDTH'(1);
          end
          S_DECODE: begin
            r_a <= w_rs_data;
            r_b <= w_rt_data;
          end
          S_EXECUTE: begin
            if (w_op == OP_ADD) begin
              r_alu <= r_a + r_b;
            end else if (w_op == OP_BEQ) begin
              if (r_a == r_b) begin
                r_pc <= r_pc + w_imm_p;
              end
            end else begin
              r_alu <= DATA_WIDTH'(w_ea);
            end
          end
          S_MEMORY: begin
            if (w_op == OP_LOAD) begin
              r_mdr <= r_dmem[w_mem_addr];
            end else begin
              r_dmem[w_mem_addr] <= r_b;
              r_display          <= r_b;
            end
          end
          S_WRITEBACK: r_display <= w_wr_data;
          default: ;
        endcase
      end
    end
  end

  assign read_address  = r_pc;
  assign display_value = r_display;
  assign state         = r_state;
  assign retire        = r_retire;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb/tb_multicycle_cpu_core.sv - scoreboard bench for multicycle_cpu_core, default and wide builds
module tb_multicycle_cpu_core;

  typedef struct {
    logic [7:0] disp;
    logic [7:0] pc;
    int         steps;
  } exp_t;

  logic        clock;
  logic        clear;
  logic        step_en;
  logic [7:0]  instr;
  logic [7:0]  read_address;
  logic [7:0]  display_value;
  logic [2:0]  state;
  logic        retire;

  logic        step_w;
  logic [10:0] instr_w;
  logic [7:0]  ra_w;
  logic [15:0] disp_w;
  logic [2:0]  state_w;
  logic        retire_w;

  logic [7:0]  rom   [256];
  logic [10:0] rom_w [256];

  int n_compared;
  int n_mismatched;

  exp_t        sb[$];
  logic [15:0] sbw[$];

  logic [7:0]  m_regs [4];
  logic [7:0]  m_dmem [4];
  logic [7:0]  m_pc;
  logic [7:0]  m_disp;
  logic [15:0] mw [8];
  logic [7:0]  mw_pc;

  assign instr   = rom[read_address];
  assign instr_w = rom_w[ra_w];

  multicycle_cpu_core dut (
    .clock         (clock),
    .clear         (clear),
    .step_en       (step_en),
    .instruction   (instr),
    .read_address  (read_address),
    .display_value (display_value),
    .state         (state),
    .retire        (retire)
  );

  multicycle_cpu_core #(
    .DATA_WIDTH (16),
    .NUM_REGS   (8),
    .DMEM_DEPTH (4),
    .PC_WIDTH   (8)
  ) dut_w (
    .clock         (clock),
    .clear         (clear),
    .step_en       (step_w),
    .instruction   (instr_w),
    .read_address  (ra_w),
    .display_value (disp_w),
    .state         (state_w),
    .retire        (retire_w)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_regs[i] = 8'(i);
      m_dmem[i] = 8'd0;
    end
    m_pc   = 8'd0;
    m_disp = 8'd0;
  endtask

  task automatic model_step(input logic [7:0] ins, output exp_t e);
    logic [1:0] op, rs, rt, rd;
    logic [7:0] imm;
    logic [1:0] ea;
    {op, rs, rt, rd} = ins;
    imm  = {{6{rd[1]}}, rd};
    ea   = 2'(m_regs[rs] + imm);
    m_pc = m_pc + 8'd1;
    e.steps = 0;
    case (op)
      2'b00: begin
        m_regs[rd] = m_regs[rs] + m_regs[rt];
        m_disp = m_regs[rd];
        e.steps = 4;
      end
      2'b01: begin
        m_regs[rt] = m_dmem[ea];
        m_disp = m_regs[rt];
        e.steps = 5;
      end
      2'b10: begin
        m_dmem[ea] = m_regs[rt];
        m_disp = m_regs[rt];
        e.steps = 4;
      end
      default: begin
        if (m_regs[rs] == m_regs[rt]) m_pc = m_pc + imm;
        e.steps = 3;
      end
    endcase
    e.disp = m_disp;
    e.pc   = m_pc;
  endtask

  function automatic logic [2:0] next_st(input logic [2:0] s, input logic [1:0] op);
    case (s)
      3'd0:    return 3'd1;
      3'd1:    return 3'd2;
      3'd2:    return (op == 2'b00) ? 3'd4 : (op == 2'b11) ? 3'd0 : 3'd3;
      3'd3:    return (op == 2'b01) ? 3'd4 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  task automatic exec(input logic [7:0] ins, input int duty);
    exp_t e;
    int   steps, cyc;
    logic [2:0] est;
    logic eret, done;
    steps = 0;
    cyc   = 0;
    est   = 3'd0;
    done  = 1'b0;
    rom[m_pc] = ins;
    model_step(ins, e);
    sb.push_back(e);
    while (!done && cyc < 60) begin
      @(negedge clock);
      step_en = (cyc % duty == 0);
      @(posedge clock);
      #1;
      cyc++;
      eret = 1'b0;
      if (step_en) begin
        steps++;
        est  = next_st(est, ins[7:6]);
        eret = (est == 3'd0);
      end
      check("state", 32'(state), 32'(est));
      check("retire", 32'(retire), 32'(eret));
      done = retire;
    end
    @(negedge clock);
    step_en = 1'b0;
    check("timeout", 32'(done), 32'd1);
    e = sb.pop_front();
    check("display", 32'(display_value), 32'(e.disp));
    check("pc", 32'(read_address), 32'(e.pc));
    check("steps", 32'(steps), 32'(e.steps));
    @(posedge clock);
    #1;
    check("retire_pulse", 32'(retire), 32'd0);
  endtask

  task automatic exec_w(input int rs, input int rt, input int rd);
    logic [10:0] ins;
    logic [15:0] ev;
    int   cyc;
    logic done;
    ins = {2'b00, 3'(rs), 3'(rt), 3'(rd)};
    rom_w[mw_pc] = ins;
    mw[rd] = mw[rs] + mw[rt];
    mw_pc  = mw_pc + 8'd1;
    sbw.push_back(mw[rd]);
    cyc  = 0;
    done = 1'b0;
    @(negedge clock);
    step_w = 1'b1;
    while (!done && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
      done = retire_w;
    end
    @(negedge clock);
    step_w = 1'b0;
    check("w_timeout", 32'(done), 32'd1);
    ev = sbw.pop_front();
    check("w_display", 32'(disp_w), 32'(ev));
    check("w_steps", 32'(cyc), 32'd4);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    model_reset();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    clock   = 1'b0;
    clear   = 1'b0;
    step_en = 1'b0;
    step_w  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i]   = 8'd0;
      rom_w[i] = 11'd0;
    end
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", 32'(read_address), 32'd0);
    check("rst_display", 32'(display_value), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_w_display", 32'(disp_w), 32'd0);
    @(negedge clock);
    clear = 1'b1;

    exec(8'b00_01_10_11, 1);
    exec(8'b10_01_11_00, 1);
    exec(8'b01_01_00_00, 1);
    exec(8'b10_11_10_01, 1);
    exec(8'b00_00_11_01, 1);
    exec(8'b11_01_01_11, 1);
    exec(8'b11_01_10_11, 1);
    exec(8'b00_10_10_10, 3);
    exec(8'b01_00_01_11, 1);
    exec(8'b11_00_01_01, 2);

    // Abort an ADD that would zero r3, then prove r3 still holds its reset value.
    pulse_clear();
    rom[0] = 8'b00_00_00_11;
    @(negedge clock);
    step_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("abort_pre_state", 32'(state), 32'd2);
    @(negedge clock);
    step_en = 1'b0;
    #2;
    clear = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_pc", 32'(read_address), 32'd0);
    check("abort_retire", 32'(retire), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    model_reset();
    exec(8'b00_11_00_01, 1);

    pulse_clear();
    exec(8'b11_00_00_10, 1);
    exec(8'b00_01_01_10, 1);

    for (int i = 0; i < 8; i++) mw[i] = 16'(i);
    mw_pc = 8'd0;
    exec_w(6, 5, 7);
    exec_w(0, 1, 4);
    for (int i = 0; i < 15; i++) begin
      exec_w(4, 4, 4);
      exec_w(4, 1, 4);
    end
    exec_w(4, 1, 4);
    check("w_pc", 32'(ra_w), 32'(mw_pc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
